// File: rtl/ln_stream_pkg.sv
// ln_stream_pkg: shared types and width helpers for the LayerNorm column
// stream scheduler.
//   state_e   - scheduler FSM state encoding
//   DEF_*     - default parameter values for the block
//   DEF_*_W   - widths derived from the default parameters
//   ptr_w()   - index width for a ring/word counter of n entries (min 1 bit)
package ln_stream_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_BUF = 3'd1,
    ST_LAUNCH   = 3'd2,
    ST_WAIT_LN  = 3'd3,
    ST_OUTPUT   = 3'd4,
    ST_DONE     = 3'd5
  } state_e;

  localparam int DEF_D_MODEL    = 64;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_NUM_BUFS   = 4;
  localparam int DEF_COL_W      = 8;

  localparam int DEF_PTR_W  = $clog2(DEF_NUM_BUFS);
  localparam int DEF_OCC_W  = $clog2(DEF_NUM_BUFS + 1);
  localparam int DEF_WCNT_W = $clog2(DEF_D_MODEL);

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ln_stream_scheduler_if.sv
// ln_stream_scheduler_if: bundles the three streams around the scheduler.
//   in_*  - word stream into the column ring (valid/ready)
//   ln_*  - LayerNorm core launch/result handshake
//   out_* - normalised column stream out (valid/ready) plus column index
// master: scheduler side, slave: surrounding environment.
interface ln_stream_scheduler_if #(
  parameter int D_MODEL    = 64,
  parameter int DATA_WIDTH = 16,
  parameter int COL_W      = 8
);

  logic                          in_valid;
  logic [DATA_WIDTH-1:0]         in_data;
  logic                          in_ready;

  logic                          ln_start;
  logic [D_MODEL*DATA_WIDTH-1:0] ln_x;
  logic                          ln_done;
  logic [D_MODEL*DATA_WIDTH-1:0] ln_y;

  logic                          out_valid;
  logic [D_MODEL*DATA_WIDTH-1:0] out_data;
  logic                          out_ready;
  logic [COL_W-1:0]              out_col;

  modport master (
    input  in_valid, in_data, ln_done, ln_y, out_ready,
    output in_ready, ln_start, ln_x, out_valid, out_data, out_col
  );

  modport slave (
    output in_valid, in_data, ln_done, ln_y, out_ready,
    input  in_ready, ln_start, ln_x, out_valid, out_data, out_col
  );

endinterface

// File: rtl/ln_col_ring_buffer.sv
// ln_col_ring_buffer: ring of NUM_BUFS column slots, each D_MODEL words.
// Words are written in order into slot wr_ptr; the D_MODEL-th word marks the
// slot full and advances wr_ptr. The reader frees slot rd_idx with free_en.
//   clk, rst    - clock, synchronous active-high reset
//   in_valid/in_data/in_ready - word stream, in_ready = slot wr_ptr not full
//   rd_idx      - slot the reader is looking at
//   rd_full     - full flag of slot rd_idx
//   rd_data     - packed contents of slot rd_idx (word 0 in the LSBs)
//   free_en     - clear the full flag of slot rd_idx this edge
//   occupancy   - number of full slots
module ln_col_ring_buffer
  import ln_stream_pkg::*;
#(
  parameter int D_MODEL    = DEF_D_MODEL,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_BUFS   = DEF_NUM_BUFS
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  input  logic [DATA_WIDTH-1:0]             in_data,
  output logic                              in_ready,
  input  logic [ptr_w(NUM_BUFS)-1:0]        rd_idx,
  output logic                              rd_full,
  output logic [D_MODEL*DATA_WIDTH-1:0]     rd_data,
  input  logic                              free_en,
  output logic [$clog2(NUM_BUFS+1)-1:0]     occupancy
);

  localparam int PTR_W  = ptr_w(NUM_BUFS);
  localparam int WCNT_W = ptr_w(D_MODEL);
  localparam int OCC_W  = $clog2(NUM_BUFS + 1);
  localparam int XW     = D_MODEL * DATA_WIDTH;

  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [WCNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic [NUM_BUFS-1:0] full_q, full_d;
  logic [OCC_W-1:0]    occ_q, occ_d;

  // Slot storage is not reset: a slot is only read once its full flag is set,
  // and every word of it has been rewritten by then.
  logic [XW-1:0]       slot_mem [NUM_BUFS];

  logic accept;
  logic fill;
  logic free_ok;

  assign in_ready = !full_q[wr_ptr_q];
  assign accept   = in_valid && in_ready;
  assign fill     = accept && (word_cnt_q == WCNT_W'(D_MODEL - 1));
  // Only a full slot can be freed, so fill and free never hit the same slot.
  assign free_ok  = free_en && full_q[rd_idx];

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    word_cnt_d = word_cnt_q;
    full_d     = full_q;
    occ_d      = occ_q;
    if (accept) begin
      word_cnt_d = fill ? '0 : word_cnt_q + 1'b1;
    end
    if (fill) begin
      full_d[wr_ptr_q] = 1'b1;
      wr_ptr_d = (wr_ptr_q == PTR_W'(NUM_BUFS - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (free_ok) begin
      full_d[rd_idx] = 1'b0;
    end
    case ({fill, free_ok})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      word_cnt_q <= '0;
      full_q     <= '0;
      occ_q      <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      word_cnt_q <= word_cnt_d;
      full_q     <= full_d;
      occ_q      <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      slot_mem[wr_ptr_q][word_cnt_q*DATA_WIDTH +: DATA_WIDTH] <= in_data;
    end
  end

  assign rd_full   = full_q[rd_idx];
  assign rd_data   = slot_mem[rd_idx];
  assign occupancy = occ_q;

endmodule

// File: rtl/ln_stream_scheduler.sv
// ln_stream_scheduler: collects a word stream into D_MODEL-word columns,
// launches the LayerNorm core on each column in ring order and streams the
// normalised columns out, cfg_num_cols columns per run.
//   clk, rst      - clock, synchronous active-high reset
//   start         - begin a run (accepted only when idle)
//   cfg_num_cols  - columns in the run, sampled with start
//   busy          - run in progress
//   done          - single-cycle pulse at run end
//   occupancy     - number of full column slots buffered
//   bus           - word input, LayerNorm core and column output streams
module ln_stream_scheduler
  import ln_stream_pkg::*;
#(
  parameter int D_MODEL    = DEF_D_MODEL,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_BUFS   = DEF_NUM_BUFS,
  parameter int COL_W      = DEF_COL_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [COL_W-1:0]              cfg_num_cols,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(NUM_BUFS+1)-1:0] occupancy,
  ln_stream_scheduler_if.master         bus
);

  localparam int PTR_W = ptr_w(NUM_BUFS);
  localparam int XW    = D_MODEL * DATA_WIDTH;

  state_e           state_q, state_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [COL_W-1:0] col_cnt_q, col_cnt_d;
  logic [COL_W-1:0] num_cols_q, num_cols_d;
  logic [XW-1:0]    ln_x_q, ln_x_d;
  logic [XW-1:0]    out_data_q, out_data_d;
  logic [COL_W-1:0] out_col_q, out_col_d;

  logic             in_ready;
  logic             rd_full;
  logic [XW-1:0]    rd_data;
  logic             free_en;
  logic [COL_W-1:0] col_nxt;

  ln_col_ring_buffer #(
    .D_MODEL    (D_MODEL),
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_BUFS   (NUM_BUFS)
  ) u_ring (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (bus.in_valid),
    .in_data   (bus.in_data),
    .in_ready  (in_ready),
    .rd_idx    (rd_ptr_q),
    .rd_full   (rd_full),
    .rd_data   (rd_data),
    .free_en   (free_en),
    .occupancy (occupancy)
  );

  // The slot is copied into ln_x on the same edge it is released, so the
  // ring can refill it while the core is still working on the copy.
  assign free_en = (state_q == ST_WAIT_BUF) && rd_full;
  assign col_nxt = col_cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rd_ptr_q   <= '0;
      col_cnt_q  <= '0;
      num_cols_q <= '0;
      ln_x_q     <= '0;
      out_data_q <= '0;
      out_col_q  <= '0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      col_cnt_q  <= col_cnt_d;
      num_cols_q <= num_cols_d;
      ln_x_q     <= ln_x_d;
      out_data_q <= out_data_d;
      out_col_q  <= out_col_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    col_cnt_d  = col_cnt_q;
    num_cols_d = num_cols_q;
    ln_x_d     = ln_x_q;
    out_data_d = out_data_q;
    out_col_d  = out_col_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          num_cols_d = cfg_num_cols;
          col_cnt_d  = '0;
          state_d    = (cfg_num_cols == '0) ? ST_DONE : ST_WAIT_BUF;
        end
      end
      ST_WAIT_BUF: begin
        if (rd_full) begin
          ln_x_d   = rd_data;
          rd_ptr_d = (rd_ptr_q == PTR_W'(NUM_BUFS - 1)) ? '0 : rd_ptr_q + 1'b1;
          state_d  = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        state_d = ST_WAIT_LN;
      end
      ST_WAIT_LN: begin
        if (bus.ln_done) begin
          out_data_d = bus.ln_y;
          out_col_d  = col_cnt_q;
          state_d    = ST_OUTPUT;
        end
      end
      ST_OUTPUT: begin
        if (bus.out_ready) begin
          col_cnt_d = col_nxt;
          state_d   = (col_nxt == num_cols_q) ? ST_DONE : ST_WAIT_BUF;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    busy          = (state_q != ST_IDLE);
    done          = (state_q == ST_DONE);
    bus.ln_start  = (state_q == ST_LAUNCH);
    bus.out_valid = (state_q == ST_OUTPUT);
    bus.in_ready  = in_ready;
    bus.ln_x      = ln_x_q;
    bus.out_data  = out_data_q;
    bus.out_col   = out_col_q;
  end

endmodule
